// File: rtl/tail_light_pkg.sv
// tail_light_pkg: shared state/direction types and per-side lamp patterns
package tail_light_pkg;
  typedef enum logic [3:0] {IDLE, L1, L2, L3, R1, R2, R3, HAZ_ON, HAZ_OFF} state_t;
  typedef enum logic {LEFT, RIGHT} dir_t;
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_S1  = 3'b001;
  localparam logic [2:0] LAMP_S2  = 3'b011;
  localparam logic [2:0] LAMP_S3  = 3'b111;
endpackage

// File: rtl/tail_light_controller_prescaler.sv
// blink_prescaler: one-cycle tick every TICK_DIV clocks
module blink_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (!reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/tail_light_controller.sv
// tail_light_controller: turn/hazard/brake lamp sequencer with comfort-blink
module tail_light_controller #(
  parameter int TICK_DIV       = 25_000_000,
  parameter int COMFORT_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  input  logic hazard,
  input  logic brake,
  output logic la,
  output logic lb,
  output logic lc,
  output logic ra,
  output logic rb,
  output logic rc,
  output logic busy
);
  import tail_light_pkg::*;
  localparam int CW = $clog2(COMFORT_CYCLES + 1);
  logic tick, haz, lseq, rseq;
  state_t state, state_n;
  dir_t dir, dir_n;
  logic [CW-1:0] count, count_n;
  logic [2:0] lp, rp;
  blink_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (.clk(clk), .reset(reset), .tick(tick));
  assign haz = hazard | (left & right);
  always_comb begin
    state_n = state;
    count_n = count;
    dir_n   = dir;
    if (tick)
      case (state)
        IDLE:
          if (haz) begin
            state_n = HAZ_ON;
            count_n = '0;
          end else if (left) begin
            state_n = L1;
            count_n = CW'(COMFORT_CYCLES);
            dir_n   = LEFT;
          end else if (right) begin
            state_n = R1;
            count_n = CW'(COMFORT_CYCLES);
            dir_n   = RIGHT;
          end else if (count != '0) state_n = dir == LEFT ? L1 : R1;
        L1, L2, L3, R1, R2, R3:
          if (haz) begin
            state_n = HAZ_ON;
            count_n = '0;
          end else if (state == L3 || state == R3) begin
            state_n = IDLE;
            count_n = count != '0 ? count - CW'(1) : '0;
          end else state_n = state_t'(state + 4'd1);
        HAZ_ON:  state_n = HAZ_OFF;
        HAZ_OFF: state_n = haz ? HAZ_ON : IDLE;
        default: state_n = IDLE;
      endcase
  end
  // The side that is not sequencing turns fully on under brake
  assign lseq = state_n inside {L1, L2, L3};
  assign rseq = state_n inside {R1, R2, R3};
  assign lp = brake && !lseq ? LAMP_S3 :
              state_n == L1 ? LAMP_S1 : state_n == L2 ? LAMP_S2 :
              (state_n == L3 || state_n == HAZ_ON) ? LAMP_S3 : LAMP_OFF;
  assign rp = brake && !rseq ? LAMP_S3 :
              state_n == R1 ? LAMP_S1 : state_n == R2 ? LAMP_S2 :
              (state_n == R3 || state_n == HAZ_ON) ? LAMP_S3 : LAMP_OFF;
  always_ff @(posedge clk)
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      dir          <= LEFT;
      {lc, lb, la} <= LAMP_OFF;
      {rc, rb, ra} <= LAMP_OFF;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      dir          <= dir_n;
      {lc, lb, la} <= lp;
      {rc, rb, ra} <= rp;
      busy         <= state_n != IDLE || count_n != '0;
    end
endmodule
